// File: rtl/capture_readout_pkg.sv
// rtl/capture_readout_pkg.sv - shared sizes and state encoding for the sample-memory readout
package capture_readout_pkg;

  localparam int CR_ADDR_WIDTH  = 10;
  localparam int CR_DATA_WIDTH  = 8;
  localparam int CR_MEMORY_SIZE = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd4
  } cr_state_e;

endpackage

// File: rtl/capture_readout.sv
// rtl/capture_readout.sv - walks the circular sample buffer and streams each word to the host
module capture_readout
  import capture_readout_pkg::*;
#(
  parameter int ADDR_WIDTH  = CR_ADDR_WIDTH,
  parameter int DATA_WIDTH  = CR_DATA_WIDTH,
  parameter int MEMORY_SIZE = CR_MEMORY_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   num_samples,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] data_read,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0]   MEM_WORDS = (ADDR_WIDTH+1)'(MEMORY_SIZE);
  localparam logic [ADDR_WIDTH:0]   ONE_LEFT  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  cr_state_e             state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH:0]   req_count;
  logic [ADDR_WIDTH-1:0] ptr_next;

  assign req_count = (num_samples > MEM_WORDS) ? MEM_WORDS : num_samples;
  // explicit wrap so non-power-of-two memories stay inside the buffer
  assign ptr_next  = (ptr == LAST_ADDR) ? '0 : ptr + ADDR_ONE;
  assign raddr     = ptr;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != ST_IDLE) begin
        // abort beats the valid/ready hold and any pending done
        state     <= ST_IDLE;
        out_valid <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              ptr       <= start_addr;
              remaining <= req_count;
              if (req_count == '0) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state <= ST_READ;
              end
            end
          end
          ST_READ: state <= ST_CAPTURE;
          ST_CAPTURE: begin
            // data_read keeps re-registering, so the word must be held here
            out_data  <= data_read;
            out_valid <= 1'b1;
            state     <= ST_SEND;
          end
          ST_SEND: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              remaining <= remaining - ONE_LEFT;
              ptr       <= ptr_next;
              if (remaining == ONE_LEFT) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state <= ST_READ;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_readout.sv
// tb/tb_capture_readout.sv - scoreboard bench for capture_readout beside a registered-read memory
module tb_capture_readout;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [9:0] start_addr = '0;
  logic [10:0] num_samples = '0;
  logic       abort = 1'b0;
  logic [9:0] raddr;
  logic [7:0] data_read = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       busy;
  logic       done;

  logic       we = 1'b0;
  logic [9:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] mem [0:1023];

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
  } sb_t;
  sb_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int hs_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  capture_readout dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .num_samples(num_samples), .abort(abort), .raddr(raddr), .data_read(data_read),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // memory_block stand-in: one-cycle registered read plus a writer port
  always @(posedge clk) begin
    data_read <= mem[raddr];
    if (we) mem[waddr] = wdata;
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i[7:0] ^ 8'hA5;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [7:0] pre(input logic [9:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every accepted word
  initial forever begin
    sb_t e;
    @(negedge clk);
    if (reset) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        hs_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got sample %0h at raddr %0d expected none", out_data, raddr);
        end else begin
          e = sb.pop_front();
          chk("sb_raddr", int'(raddr), int'(e.addr));
          chk("sb_data", int'(out_data), int'(e.data));
        end
      end
    end
  end

  task automatic push_run(input int a, input int n);
    for (int k = 0; k < n; k++) begin
      logic [9:0] ad;
      ad = 10'((a + k) % 1024);
      sb.push_back({ad, pre(ad)});
    end
  endtask

  task automatic pulse_start(input int a, input int n);
    @(posedge clk); #1;
    start_addr = 10'(a);
    num_samples = 11'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 20);
    if (!out_valid) chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic wait_hs(input int target);
    int k = 0;
    while (hs_cnt < target && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (hs_cnt < target) chk("wait_hs_timeout", hs_cnt, target);
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == d0) chk("wait_done_timeout", done_cnt, d0 + 1);
    repeat (3) @(negedge clk);
    chk("done_single_pulse", done_cnt, d0 + 1);
  endtask

  initial begin
    int lat, base, d0;
    logic [7:0] held;

    repeat (2) @(negedge clk);
    chk("rst_raddr", int'(raddr), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // basic run, hand-computed words
    base = hs_cnt;
    sb.push_back({10'd5, 8'hA0});
    sb.push_back({10'd6, 8'hA3});
    sb.push_back({10'd7, 8'hA2});
    sb.push_back({10'd8, 8'hAD});
    pulse_start(5, 4);
    wait_valid(lat);
    chk("first_valid_latency", lat, 3);
    wait_done(40);
    chk("basic_count", hs_cnt - base, 4);
    chk("done_after_last_hs", done_cyc, hs_cyc + 1);
    chk("basic_sb_empty", sb.size(), 0);

    // wrap around the top of memory
    base = hs_cnt;
    push_run(1022, 4);
    pulse_start(1022, 4);
    wait_done(40);
    chk("wrap_count", hs_cnt - base, 4);
    chk("wrap_sb_empty", sb.size(), 0);

    // backpressure on sample 2 while the writer overwrites that word
    base = hs_cnt;
    push_run(100, 3);
    pulse_start(100, 3);
    wait_hs(base + 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_valid(lat);
    held = out_data;
    chk("bp_held_word", int'(held), int'(pre(10'd101)));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      we = (i == 1);
      waddr = raddr;
      wdata = 8'h5A;
      @(negedge clk);
      chk("bp_valid_hold", int'(out_valid), 1);
      chk("bp_data_hold", int'(out_data), int'(held));
    end
    @(posedge clk); #1;
    we = 1'b0;
    out_ready = 1'b1;
    wait_done(40);
    chk("bp_count", hs_cnt - base, 3);
    chk("bp_sb_empty", sb.size(), 0);
    @(posedge clk); #1;
    we = 1'b1; waddr = 10'd101; wdata = pre(10'd101);
    @(posedge clk); #1;
    we = 1'b0;

    // zero samples: done at T+1, no data
    base = hs_cnt;
    pulse_start(600, 0);
    @(negedge clk);
    chk("zero_done_t1", int'(done), 1);
    chk("zero_no_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("zero_done_clear", int'(done), 0);
    chk("zero_idle", int'(busy), 0);
    chk("zero_count", hs_cnt - base, 0);

    // oversize count clamps to the whole memory
    base = hs_cnt;
    push_run(7, 1024);
    pulse_start(7, 2000);
    wait_done(3300);
    chk("clamp_count", hs_cnt - base, 1024);
    chk("clamp_sb_empty", sb.size(), 0);

    // abort during SEND of sample 3 of 8
    base = hs_cnt;
    d0 = done_cnt;
    push_run(200, 8);
    pulse_start(200, 8);
    wait_hs(base + 2);
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_valid(lat);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(out_valid), 0);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_count", hs_cnt - base, 2);
    chk("abort_dropped", sb.size(), 6);
    sb.delete();

    // normal run after abort, with a start pulsed while busy
    base = hs_cnt;
    push_run(300, 2);
    pulse_start(300, 2);
    @(posedge clk); #1;
    chk("restart_busy", int'(busy), 1);
    start_addr = 10'd0;
    num_samples = 11'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40);
    chk("busy_start_ignored", hs_cnt - base, 2);
    chk("restart_sb_empty", sb.size(), 0);

    // abort landing on the final handshake
    base = hs_cnt;
    d0 = done_cnt;
    push_run(400, 2);
    pulse_start(400, 2);
    wait_hs(base + 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_valid(lat);
    @(posedge clk); #1;
    abort = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("final_abort_busy", int'(busy), 0);
    repeat (4) @(negedge clk);
    chk("final_abort_no_done", done_cnt, d0);
    chk("final_abort_count", hs_cnt - base, 2);

    // asynchronous reset mid-readout
    d0 = done_cnt;
    push_run(500, 4);
    out_ready = 1'b0;
    pulse_start(500, 4);
    wait_valid(lat);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_raddr", int'(raddr), 0);
    chk("arst_data", int'(out_data), 0);
    chk("arst_done", int'(done), 0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_no_done", done_cnt, d0);
    chk("arst_idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/capture_readout.md
Name: capture_readout

Overview:
- Reader side of the analyzer's sample memory.
- After capture completes, it walks the circular buffer from a given start address for a given sample count. For each sample it issues a read address, waits out the memory's 1-cycle registered read latency, and latches the word.
- Each word is presented on a valid/ready stream toward the host transmitter (UART/JTAG formatter).
- Sits beside memory_block, driving its raddr and consuming its data_read.

Parameters:
- ADDR_WIDTH, 10, memory address width (tracks `ADDR_WIDTH in define.v)
- DATA_WIDTH, 8, sample width (tracks `DATA_WIDTH)
- MEMORY_SIZE, 1024, number of memory words, ≤ 2^ADDR_WIDTH (tracks `MEMORY_SIZE)

Ports:
- clk  input  1  single clock, all logic on posedge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin readout; sampled only in IDLE
- start_addr  input  ADDR_WIDTH  first address to read
- num_samples  input  ADDR_WIDTH+1  samples to read; 0 = none; values > MEMORY_SIZE clamp to MEMORY_SIZE
- abort  input  1  cancel readout in progress
- raddr  output  ADDR_WIDTH  read address to memory
- data_read  input  DATA_WIDTH  memory read data, valid 1 cycle after raddr
- out_data  output  DATA_WIDTH  sample to host
- out_valid  output  1  out_data valid
- out_ready  input  1  host accepts
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse when the last sample is accepted (or on num_samples=0)

Behaviour:
- Reset (async assert, sync deassert by the system):
  - State IDLE; ptr = 0, remaining = 0.
  - raddr = 0, out_data = 0, out_valid = 0, busy = 0, done = 0.
  - Reset mid-readout drops out_valid immediately; no done pulse is produced.
- raddr is driven from the internal ptr register and is stable during READ.
- States:
  - IDLE:
    - On start, latch ptr = start_addr and remaining = min(num_samples, MEMORY_SIZE).
    - If the latched count is 0, go to DONE; else go to READ.
  - READ: raddr = ptr; memory samples the address at the end of this cycle. Go to CAPTURE.
  - CAPTURE:
    - data_read now reflects memory[ptr]; register it into out_data at the end of this cycle.
    - Set out_valid = 1 and go to SEND.
  - SEND:
    - Hold out_data and out_valid = 1 until out_ready = 1; out_data never changes while valid and not accepted.
    - On handshake: clear out_valid, decrement remaining, and advance ptr (MEMORY_SIZE-1 wraps to 0, including non-power-of-two sizes).
    - If remaining was 1, go to DONE; else go to READ.
  - DONE: done = 1 for exactly one cycle, then go to IDLE.
- Latency and throughput:
  - start in cycle T → out_valid first high in cycle T+3.
  - Best-case throughput is 1 sample per 3 cycles with out_ready held high.
- Latching out_data is mandatory: data_read re-registers every clock and can change if the writer is active.
- start while busy = 1 is ignored.
- start and abort together in IDLE: abort wins and start is ignored.
- abort in any non-IDLE state:
  - Next cycle the block is in IDLE with out_valid = 0 and busy = 0.
  - No done pulse is produced, and a pending sample is dropped.
  - abort overrides the valid/ready hold rule.
- An abort coinciding with the final handshake still wins: no done pulse.
- num_samples = MEMORY_SIZE reads every word exactly once, ending at start_addr-1 (mod MEMORY_SIZE).

Decomposition:
- define.v (shared): ADDR_WIDTH, DATA_WIDTH, MEMORY_SIZE defaults, and state encodings (IDLE, READ, CAPTURE, SEND, DONE as 3-bit localparams).
- No sub-module. The count/pointer logic and FSM are small enough to live together in one file.
- The testbench instantiates memory_block next to this block, sharing clk.

Test Plan:
- Preload mem[i] = i[7:0]^8'hA5; start_addr=5, num_samples=4, out_ready=1 → out_data 0xA0,0xA3,0xA2,0xAD; first out_valid at T+3; done pulses once, one cycle after the 4th handshake.
- Wrap: start_addr=1022, num_samples=4 → raddr sequence 1022,1023,0,1; data matches mem at those addresses.
- Backpressure: out_ready low for 5 cycles on sample 2 → out_valid and out_data held constant for those cycles, while the writer also writes mem[ptr]; no sample lost or duplicated.
- Edge counts:
  - num_samples=0 → done pulses at T+1, out_valid never asserts.
  - num_samples=2000 → exactly 1024 samples, then done.
- Abort: assert abort during SEND of sample 3 of 8 → next cycle IDLE, busy=0, out_valid=0, no done; a subsequent start runs normally.
- Disruptions mid-readout:
  - reset low mid-readout → all outputs 0 asynchronously.
  - start pulsed while busy → ignored; sample count unchanged.
